// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX/MEM/WB control pipeline with hazard detection, forwarding selects and a retire counter
module ctrl_pipe #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [4:0]       i_rdReg1,
  input  logic [4:0]       i_rdReg2,
  input  logic [13:0]      i_ctrlEX,
  input  logic [2:0]       i_ctrlMEM,
  input  logic [6:0]       i_ctrlWB,
  input  logic             i_branchTaken,
  input  logic             i_memStall,
  output logic             o_stallIF,
  output logic             o_flushIF,
  output logic             o_validEX,
  output logic [13:0]      o_ctrlEX,
  output logic [4:0]       o_rsEX1,
  output logic [4:0]       o_rsEX2,
  output logic             o_validMEM,
  output logic [2:0]       o_ctrlMEM,
  output logic             o_validWB,
  output logic [6:0]       o_ctrlWB,
  output logic [1:0]       o_fwdA,
  output logic [1:0]       o_fwdB,
  output logic [CNT_W-1:0] o_retired
);
  logic [2:0] ex_mem;
  logic [6:0] ex_wb;
  logic [6:0] mem_wb;
  logic       load_use;
  logic       adv;
  // hazard detection and stall/flush decisions from inputs and EX state
  always_comb begin
    load_use  = ex_mem[1] && ex_wb[4:0] != 5'd0 && i_valid &&
                (ex_wb[4:0] == i_rdReg1 || ex_wb[4:0] == i_rdReg2);
    o_stallIF = i_memStall || (!i_branchTaken && load_use);
    o_flushIF = !i_memStall && i_branchTaken;
    adv       = i_valid && !i_branchTaken && !load_use;
  end
  // forwarding selects: the younger MEM producer wins over WB, x0 never forwards
  always_comb begin
    o_fwdA = (mem_wb[6] && mem_wb[4:0] != 5'd0 && mem_wb[4:0] == o_rsEX1) ? 2'b10 :
             (o_ctrlWB[6] && o_ctrlWB[4:0] != 5'd0 && o_ctrlWB[4:0] == o_rsEX1) ? 2'b01 : 2'b00;
    o_fwdB = (mem_wb[6] && mem_wb[4:0] != 5'd0 && mem_wb[4:0] == o_rsEX2) ? 2'b10 :
             (o_ctrlWB[6] && o_ctrlWB[4:0] != 5'd0 && o_ctrlWB[4:0] == o_rsEX2) ? 2'b01 : 2'b00;
  end
  // stage registers: reset flushes everything, memory stall freezes everything, otherwise advance
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_validEX  <= 1'b0;
      o_ctrlEX   <= '0;
      o_rsEX1    <= '0;
      o_rsEX2    <= '0;
      ex_mem     <= '0;
      ex_wb      <= '0;
      o_validMEM <= 1'b0;
      o_ctrlMEM  <= '0;
      mem_wb     <= '0;
      o_validWB  <= 1'b0;
      o_ctrlWB   <= '0;
      o_retired  <= '0;
    end else if (!i_memStall) begin
      o_validEX  <= adv;
      o_ctrlEX   <= adv ? i_ctrlEX : '0;
      o_rsEX1    <= adv ? i_rdReg1 : '0;
      o_rsEX2    <= adv ? i_rdReg2 : '0;
      ex_mem     <= adv ? i_ctrlMEM : '0;
      ex_wb      <= adv ? i_ctrlWB : '0;
      o_validMEM <= o_validEX;
      o_ctrlMEM  <= ex_mem;
      mem_wb     <= ex_wb;
      o_validWB  <= o_validMEM;
      o_ctrlWB   <= mem_wb;
      o_retired  <= o_retired + CNT_W'(o_validWB);
    end
  end
endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: randomized scoreboard bench for ctrl_pipe against an instruction-level pipeline model
module tb_ctrl_pipe;
  logic clk = 1'b0;
  logic rst, valid, br, ms;
  logic [4:0] r1, r2;
  logic [13:0] cex;
  logic [2:0] cmem;
  logic [6:0] cwb;
  logic stall, flush, vex, vmem, vwb;
  logic [13:0] oex;
  logic [4:0] rs1, rs2;
  logic [2:0] omem;
  logic [6:0] owb;
  logic [1:0] fa, fb;
  logic [31:0] ret;
  logic s4, f4, ve4, vm4, vw4;
  logic [13:0] oe4;
  logic [4:0] ra4, rb4;
  logic [2:0] om4;
  logic [6:0] ow4;
  logic [1:0] fa4, fb4;
  logic [3:0] ret4;

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_rdReg1(r1), .i_rdReg2(r2),
    .i_ctrlEX(cex), .i_ctrlMEM(cmem), .i_ctrlWB(cwb), .i_branchTaken(br), .i_memStall(ms),
    .o_stallIF(stall), .o_flushIF(flush), .o_validEX(vex), .o_ctrlEX(oex),
    .o_rsEX1(rs1), .o_rsEX2(rs2), .o_validMEM(vmem), .o_ctrlMEM(omem),
    .o_validWB(vwb), .o_ctrlWB(owb), .o_fwdA(fa), .o_fwdB(fb), .o_retired(ret)
  );

  ctrl_pipe #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_rdReg1(r1), .i_rdReg2(r2),
    .i_ctrlEX(cex), .i_ctrlMEM(cmem), .i_ctrlWB(cwb), .i_branchTaken(br), .i_memStall(ms),
    .o_stallIF(s4), .o_flushIF(f4), .o_validEX(ve4), .o_ctrlEX(oe4),
    .o_rsEX1(ra4), .o_rsEX2(rb4), .o_validMEM(vm4), .o_ctrlMEM(om4),
    .o_validWB(vw4), .o_ctrlWB(ow4), .o_fwdA(fa4), .o_fwdB(fb4), .o_retired(ret4)
  );

  typedef struct {
    logic v;
    logic [13:0] ex;
    logic [4:0] rs1, rs2;
    logic [2:0] mem;
    logic [6:0] wb;
  } instr_t;

  typedef struct {
    logic stall, flush, vex, vmem, vwb;
    logic [13:0] cex;
    logic [4:0] rs1, rs2;
    logic [2:0] cmem;
    logic [6:0] cwb;
    logic [1:0] fa, fb;
    longint ret;
  } exp_t;

  instr_t pipe[3];
  instr_t bubble = '{v: 1'b0, ex: '0, rs1: '0, rs2: '0, mem: '0, wb: '0};
  longint retired_cnt;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit is_load_use();
    instr_t e = pipe[0];
    return e.mem[1] && e.wb[4:0] != 0 && valid && (e.wb[4:0] == r1 || e.wb[4:0] == r2);
  endfunction

  function automatic logic [1:0] fwd_sel(logic [4:0] rs);
    if (pipe[1].wb[6] && pipe[1].wb[4:0] != 0 && pipe[1].wb[4:0] == rs) return 2'b10;
    if (pipe[2].wb[6] && pipe[2].wb[4:0] != 0 && pipe[2].wb[4:0] == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step();
    instr_t nxt;
    if (rst) begin
      foreach (pipe[i]) pipe[i] = bubble;
      retired_cnt = 0;
    end else if (!ms) begin
      if (pipe[2].v) retired_cnt++;
      nxt = (br || is_load_use() || !valid) ? bubble :
            '{v: 1'b1, ex: cex, rs1: r1, rs2: r2, mem: cmem, wb: cwb};
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nxt;
    end
  endtask

  task automatic expect_now();
    exp_t e;
    e.stall = ms || (!br && is_load_use());
    e.flush = !ms && br;
    e.vex = pipe[0].v;
    e.cex = pipe[0].ex;
    e.rs1 = pipe[0].rs1;
    e.rs2 = pipe[0].rs2;
    e.vmem = pipe[1].v;
    e.cmem = pipe[1].mem;
    e.vwb = pipe[2].v;
    e.cwb = pipe[2].wb;
    e.fa = fwd_sel(pipe[0].rs1);
    e.fb = fwd_sel(pipe[0].rs2);
    e.ret = retired_cnt;
    q.push_back(e);
  endtask

  task automatic drive_random(int cyc);
    rst   = cyc < 2 || $urandom_range(0, 99) < 2;
    ms    = $urandom_range(0, 99) < 12;
    br    = $urandom_range(0, 99) < 10;
    valid = $urandom_range(0, 99) < 85;
    r1    = 5'($urandom_range(0, 3));
    r2    = 5'($urandom_range(0, 3));
    cex   = 14'($urandom);
    cmem  = {1'($urandom), 1'($urandom_range(0, 99) < 40), 1'($urandom)};
    cwb   = {1'($urandom_range(0, 99) < 75), 1'($urandom), 5'($urandom_range(0, 3))};
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("stallIF", 32'(stall), 32'(e.stall));
        check("flushIF", 32'(flush), 32'(e.flush));
        check("validEX", 32'(vex), 32'(e.vex));
        check("ctrlEX", 32'(oex), 32'(e.cex));
        check("rsEX", {22'd0, rs1, rs2}, {22'd0, e.rs1, e.rs2});
        check("validMEM", 32'(vmem), 32'(e.vmem));
        check("ctrlMEM", 32'(omem), 32'(e.cmem));
        check("validWB", 32'(vwb), 32'(e.vwb));
        check("ctrlWB", 32'(owb), 32'(e.cwb));
        check("fwdA", 32'(fa), 32'(e.fa));
        check("fwdB", 32'(fb), 32'(e.fb));
        check("retired", ret, 32'(e.ret % 64'h1_0000_0000));
        check("retired4", 32'(ret4), 32'(e.ret % 16));
      end
    end
  end

  initial begin : driver
    rst = 1'b1; valid = 1'b0; br = 1'b0; ms = 1'b0;
    r1 = '0; r2 = '0; cex = '0; cmem = '0; cwb = '0;
    foreach (pipe[i]) pipe[i] = bubble;
    retired_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      model_step();
      drive_random(c);
      expect_now();
    end
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ctrl_pipe.md
Name: ctrl_pipe

Overview:
- Downstream receiver of the ID-stage control bundles (ctrlEX, ctrlMEM, ctrlWB) and source-register indices.
- Carries them through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and taken-branch flushes, and applies a global memory stall.
- Generates EX operand forwarding selects and counts retired instructions.
- Sits between the ID control decoder and the EX/MEM/WB datapath.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous active-high reset
i_valid  input  1  ID stage holds a real instruction
i_rdReg1  input  5  rs1 index from ID
i_rdReg2  input  5  rs2 index from ID
i_ctrlEX  input  14  ALUop[13:12], ALUSrc[11:10], func3[9:7], func7[6:0]
i_ctrlMEM  input  3  Branch[2], MemRead[1], MemWrite[0]
i_ctrlWB  input  7  RegWrite[6], MemtoReg[5], rd[4:0]
i_branchTaken  input  1  branch in EX resolved taken
i_memStall  input  1  data memory not ready; freeze pipeline
o_stallIF  output  1  hold PC and IF/ID register
o_flushIF  output  1  zero IF/ID register
o_validEX  output  1  EX stage valid
o_ctrlEX  output  14  EX-stage control
o_rsEX1  output  5  EX-stage rs1
o_rsEX2  output  5  EX-stage rs2
o_validMEM  output  1  MEM stage valid
o_ctrlMEM  output  3  MEM-stage control
o_validWB  output  1  WB stage valid
o_ctrlWB  output  7  WB-stage control
o_fwdA  output  2  EX operand A select: 00 regfile, 01 WB result, 10 MEM result
o_fwdB  output  2  EX operand B select, same encoding
o_retired  output  CNT_W  count of valid instructions leaving WB

Behaviour:
- Bubble definition: valid=0; ctrlEX, ctrlMEM, ctrlWB and rs all zero.
- Stage registers:
  - EX stage holds ctrlEX, rs1, rs2, ctrlMEM, ctrlWB.
  - MEM stage holds ctrlMEM, ctrlWB.
  - WB stage holds ctrlWB.
- Reset: while i_rst is high at a clock edge, all stages load the bubble and o_retired loads 0. This applies mid-operation too: a reset discards all in-flight contents in one cycle.
- Priority per cycle: i_rst > i_memStall > i_branchTaken > load-use > normal advance.
- i_memStall=1:
  - All stage registers and o_retired hold.
  - o_stallIF=1, o_flushIF=0.
  - i_branchTaken is ignored; EX holds the branch, so the flag re-presents after the stall.
- i_branchTaken=1 (no memStall):
  - o_flushIF=1, o_stallIF=0.
  - EX loads the bubble; the ID instruction is discarded.
  - MEM and WB advance normally.
- Load-use hazard is asserted when all of the following hold:
  - EX ctrlMEM[1]=1;
  - EX rd!=0;
  - i_valid=1;
  - rd==i_rdReg1 or rd==i_rdReg2.
- Load-use response: o_stallIF=1, EX loads the bubble, MEM/WB advance. This gives exactly one stall cycle per load-use pair.
- Normal advance: EX<=ID inputs, with valid=i_valid. If i_valid=0, EX loads the bubble. MEM<=EX, WB<=MEM.
- o_stallIF and o_flushIF are combinational from the current inputs and EX state; with no hazard, stall, or flush both are 0.
- Forwarding (combinational from registered state), computed for o_fwdA against o_rsEX1 and for o_fwdB against o_rsEX2:
  - 10 if MEM RegWrite=1 and MEM rd!=0 and MEM rd==rs.
  - Else 01 if WB RegWrite=1 and WB rd!=0 and WB rd==rs.
  - Else 00.
  - MEM has priority over WB when both match.
- rd==0 never forwards or stalls.
- o_retired increments by 1 on each non-stalled cycle where o_validWB=1. It wraps modulo 2^CNT_W.
- Outputs o_ctrlEX..o_ctrlWB and o_valid* are direct register outputs. ID→EX latency is 1 cycle, EX→WB is 2 cycles.

Test Plan:
1. Reset mid-stream: three valid R-types in flight, pulse i_rst one cycle -> next cycle all o_valid*=0, all ctrl=0, o_retired=0.
2. EX→MEM forwarding: add x3,x1,x2 then sub x4,x3,x5 back-to-back -> when sub is in EX, o_fwdA=10, o_fwdB=00. Add nop then sub -> o_fwdA=01.
3. Load-use: lw x5 (ctrlMEM=010, ctrlWB=11_00101) then add x6,x5,x1 -> one cycle of o_stallIF=1 with EX bubble; add enters EX the next cycle with o_fwdA=01.
4. Branch flush: i_branchTaken=1 for one cycle -> o_flushIF=1, EX bubble next cycle, MEM holds the branch's ctrl. Assert simultaneously with a load-use -> o_stallIF=0.
5. Memory stall: i_memStall=1 for 3 cycles with a valid instruction in WB -> all stage outputs constant, o_stallIF=1, o_retired unchanged. After release, o_retired increments once.
6. x0 destination: lw x0 then add x6,x0,x0 -> no stall, o_fwdA=o_fwdB=00. Preset o_retired to 2^CNT_W-1 via a shortened CNT_W=4 run -> wraps to 0.
